bootram_word_port: RTL and testbench

BOOTRAM_WORD_PORT -- requirements
Module: bootram_word_port

---
 rtl/bootram_word_port_pkg.sv | 24 ++
 rtl/bootram_word_port_if.sv | 30 +++
 rtl/bootram_word_port.sv | 134 +++++++++++++
 tb/tb_bootram_word_port.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bootram_word_port_pkg.sv
// Shared types and sizes for the boot RAM word port.
// Word accesses are split into four byte-lane RAM operations.
package bootram_word_port_pkg;

  localparam int WORD_BYTES = 4;
  localparam int RAM_AW     = 11;
  localparam int WORD_AW    = 9;
  localparam int LANE_W     = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [7:0] lane_byte(
    input logic [31:0]       w,
    input logic [LANE_W-1:0] k
  );
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/bootram_word_port_if.sv
// CPU-side word bus of the boot RAM port.
// Master is the CPU, slave is the word port.
interface bootram_word_port_if;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/bootram_word_port.sv
// Word-wide CPU port onto a byte-wide registered boot RAM.
// One request becomes four sequential byte-lane accesses.
module bootram_word_port
  import bootram_word_port_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [RAM_AW-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic               rst_n;

  state_e             state_q, state_d;
  logic [LANE_W-1:0]  idx_q, idx_d;
  logic [WORD_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               is_read;
  logic [LANE_W-1:0]  cap_lane;
  logic               unused_addr;

  assign unused_addr = ^{mem_addr[31:WORD_AW+2], mem_addr[1:0]};
  assign is_read     = (wstrb_q == 4'b0000);
  assign rst_n       = rst_sync_q[1];

  // Reset release is retimed to clk; assertion stays asynchronous.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchronizer flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= rst_sync_d;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: reads need one extra cycle for the last lane.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (mem_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (idx_q == 2'd3)
                  state_d = is_read ? ST_DRAIN : ST_DONE;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch, lane counter and read-byte assembly.
  always_comb begin
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    cap_lane = idx_q - 2'd1;
    if (state_q == ST_IDLE && mem_valid) begin
      addr_d  = mem_addr[WORD_AW+1:2];
      wdata_d = mem_wdata;
      wstrb_d = mem_wstrb;
      idx_d   = '0;
    end
    if (state_q == ST_ISSUE) begin
      idx_d = idx_q + 2'd1;
      if (is_read && idx_q != 2'd0)
        rdata_d[{cap_lane, 3'b000} +: 8] = ram_dout;
    end
    if (state_q == ST_DRAIN)
      rdata_d[31:24] = ram_dout;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  // FSM outputs: RAM strobes only while issuing, ready only in DONE.
  always_comb begin
    mem_ready = 1'b0;
    ram_ce    = 1'b0;
    ram_wre   = 1'b0;
    ram_ad    = '0;
    ram_din   = '0;
    unique case (1'b1)
      (state_q == ST_ISSUE): begin
        ram_ad  = {addr_q, idx_q};
        ram_din = lane_byte(wdata_q, idx_q);
        ram_ce  = is_read | wstrb_q[idx_q];
        ram_wre = ~is_read & wstrb_q[idx_q];
      end
      (state_q == ST_DONE): mem_ready = 1'b1;
      default: ;
    endcase
  end

  assign mem_rdata = rdata_q;
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

endmodule

// File: tb/tb_bootram_word_port.sv
// Directed bench for bootram_word_port.
// Byte RAM modelled as a registered-output array.
module tb_bootram_word_port;

  logic        clk;
  logic        resetn;
  logic        ram_ce, ram_oce, ram_wre, ram_reset;
  logic [10:0] ram_ad;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic [7:0]  ram [0:2047];
  logic [10:0] ad_log [$];

  int checks;
  int errors;

  bootram_word_port_if bus ();

  bootram_word_port dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (bus.mem_valid),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_wstrb (bus.mem_wstrb),
    .mem_ready (bus.mem_ready),
    .mem_rdata (bus.mem_rdata),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_wre   (ram_wre),
    .ram_reset (ram_reset),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce && ram_wre) ram[ram_ad] <= ram_din;
    if (ram_ce && !ram_wre) ram_dout <= ram[ram_ad];
    if (ram_ce) ad_log.push_back(ram_ad);
  end

  // Starts just after a rising edge (cycle 0); returns just after one.
  task automatic run_txn(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output int          lat,
    output logic [31:0] rd
  );
    lat = -1;
    rd  = '0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        lat = c;
        rd  = bus.mem_rdata;
        bus.mem_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (c == 0) begin
        bus.mem_addr  = a ^ 32'hFFFF_F7FC;
        bus.mem_wdata = ~d;
        bus.mem_wstrb = ~s;
      end
    end
    bus.mem_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: ready=%b rdata=%h want 0/0",
               bus.mem_ready, bus.mem_rdata);
    end
    checks++;
    if (ram_ce !== 1'b0 || ram_wre !== 1'b0 ||
        ram_ad !== 11'h0 || ram_din !== 8'h0) begin
      errors++;
      $display("FAIL reset_ram: ce=%b wre=%b ad=%h din=%h want 0",
               ram_ce, ram_wre, ram_ad, ram_din);
    end
    checks++;
    if (ram_oce !== 1'b1 || ram_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_const: oce=%b reset=%b want 1/0",
               ram_oce, ram_reset);
    end
  endtask

  task automatic test_read;
    int          lat;
    logic [31:0] rd;
    run_txn(32'h0, 32'h0, 4'h0, lat, rd);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL read_latency: got %0d want 6", lat);
    end
    checks++;
    if (rd !== 32'h1313136F) begin
      errors++;
      $display("FAIL read_data: got %h want 1313136f", rd);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_rdata !== 32'h1313136F) begin
      errors++;
      $display("FAIL read_hold: got %h want 1313136f", bus.mem_rdata);
    end
  endtask

  task automatic test_full_write;
    int          lat;
    logic [31:0] rd;
    logic [31:0] got;
    run_txn(32'h10, 32'hDEADBEEF, 4'hF, lat, rd);
    got = {ram[11'h13], ram[11'h12], ram[11'h11], ram[11'h10]};
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL write_latency: got %0d want 5", lat);
    end
    checks++;
    if (got !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_bytes: got %h want deadbeef", got);
    end
    run_txn(32'h10, 32'h0, 4'h0, lat, rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_readback: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_partial_write;
    int          lat;
    logic [31:0] rd;
    run_txn(32'h20, 32'hAABBCCDD, 4'b0101, lat, rd);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL partial_latency: got %0d want 5", lat);
    end
    run_txn(32'h20, 32'h0, 4'h0, lat, rd);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL partial_readback: got %h want 11bb33dd", rd);
    end
  endtask

  task automatic test_back_to_back;
    int          r1;
    int          r2;
    logic [31:0] rd1;
    logic [31:0] got;
    r1  = -1;
    r2  = -1;
    rd1 = '0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h4;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    for (int c = 0; c < 30 && r2 < 0; c++) begin
      @(negedge clk);
      if (r1 >= 0 && c == r1 + 1) begin
        checks++;
        if (bus.mem_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_pulse_width: ready=%b want 0", bus.mem_ready);
        end
      end
      if (bus.mem_ready) begin
        if (r1 < 0) begin
          r1  = c;
          rd1 = bus.mem_rdata;
          bus.mem_addr  = 32'h8;
          bus.mem_wdata = 32'hCAFEF00D;
          bus.mem_wstrb = 4'hF;
        end else begin
          r2 = c;
          bus.mem_valid = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.mem_valid = 1'b0;
    checks++;
    if (r1 !== 6 || rd1 !== 32'h04030201) begin
      errors++;
      $display("FAIL b2b_read: at %0d data %h want 6 04030201", r1, rd1);
    end
    checks++;
    if (r2 < 0 || r2 - r1 !== 6) begin
      errors++;
      $display("FAIL b2b_gap: got %0d want 6", r2 - r1);
    end
    got = {ram[11'h0B], ram[11'h0A], ram[11'h09], ram[11'h08]};
    checks++;
    if (got !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_write: got %h want cafef00d", got);
    end
  endtask

  task automatic test_alias;
    int          lat;
    logic [31:0] rd;
    logic [43:0] seq;
    ad_log.delete();
    run_txn(32'h0000_0803, 32'h0, 4'h0, lat, rd);
    seq = '1;
    if (ad_log.size() == 4)
      seq = {ad_log[0], ad_log[1], ad_log[2], ad_log[3]};
    checks++;
    if (seq !== {11'h000, 11'h001, 11'h002, 11'h003}) begin
      errors++;
      $display("FAIL alias_addr: n=%0d seq=%h want 000/001/002/003",
               ad_log.size(), seq);
    end
    checks++;
    if (lat !== 6 || rd !== 32'h1313136F) begin
      errors++;
      $display("FAIL alias_data: lat %0d data %h want 6 1313136f", lat, rd);
    end
  endtask

  task automatic test_reset_mid_write;
    logic        seen;
    logic [31:0] got;
    seen = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h30;
    bus.mem_wdata = 32'h55667788;
    bus.mem_wstrb = 4'hF;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) seen = 1'b1;
    end
    checks++;
    if (ram_ce !== 1'b1 || ram_ad !== 11'h032 || ram_din !== 8'h66) begin
      errors++;
      $display("FAIL midrst_lane2: ce=%b ad=%h din=%h want 1 032 66",
               ram_ce, ram_ad, ram_din);
    end
    resetn = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    checks++;
    if (ram_ce !== 1'b0 || ram_wre !== 1'b0 || ram_ad !== 11'h0 ||
        ram_din !== 8'h0 || bus.mem_ready !== 1'b0 ||
        bus.mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs: ce=%b wre=%b ad=%h din=%h rdy=%b rd=%h",
               ram_ce, ram_wre, ram_ad, ram_din, bus.mem_ready,
               bus.mem_rdata);
    end
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_ready) seen = 1'b1;
    end
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_ready) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    got = {ram[11'h33], ram[11'h32], ram[11'h31], ram[11'h30]};
    checks++;
    if (got !== 32'h0000_7788) begin
      errors++;
      $display("FAIL midrst_bytes: got %h want 00007788", got);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: ready seen=%b want 0", seen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    ram_dout = 8'h00;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    ram[0] = 8'h6F; ram[1] = 8'h13; ram[2] = 8'h13; ram[3] = 8'h13;
    ram[4] = 8'h01; ram[5] = 8'h02; ram[6] = 8'h03; ram[7] = 8'h04;
    ram[32] = 8'h44; ram[33] = 8'h33; ram[34] = 8'h22; ram[35] = 8'h11;

    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    test_read();
    test_full_write();
    test_partial_write();
    test_back_to_back();
    test_alias();
    test_reset_mid_write();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
